// File: rtl/lift_pkg.sv
// lift_pkg: definitions shared by the pending-call register and the lift
// controller.
//   floor_t       - floor encoding (GROUND/FIRST/SECOND, 3 is illegal)
//   door_state_t  - door sequencing states (IDLE/OPEN/CLOSE)
//   DWELL_DEFAULT - default door-open dwell in clk cycles
//   CALL_*        - bit positions of the four pending-call latches
//   floor_mask()  - selects the latches that belong to a given floor
package lift_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } door_state_t;

    localparam int DWELL_DEFAULT = 8;

    // Latch vector layout, matches the pend output {S, F[1], F[0], G}
    localparam int CALL_G  = 0;
    localparam int CALL_FD = 1;
    localparam int CALL_FU = 2;
    localparam int CALL_S  = 3;

    // Latches served by a stop at 'floor'. Floor 3 is not a stop, so it
    // selects nothing and nothing gets cleared there.
    function automatic logic [3:0] floor_mask(input logic [1:0] floor);
        case (floor)
            GROUND:  return 4'b0001;
            FIRST:   return 4'b0110;
            SECOND:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lift_call_register_if.sv
// lift_call_register_if: button/floor inputs and request outputs between the
// call register and its surroundings.
//   slave  - the call register: takes buttons and cur_floor, drives requests
//   master - the environment: drives buttons and cur_floor, reads requests
// Signals: btn_g, btn_f_dn, btn_f_up, btn_s, car_btn[2:0], cur_floor[1:0],
//          G, F[1:0], S, door_open, pend[3:0]
interface lift_call_register_if;
    logic       btn_g;
    logic       btn_f_dn;
    logic       btn_f_up;
    logic       btn_s;
    logic [2:0] car_btn;
    logic [1:0] cur_floor;
    logic       G;
    logic [1:0] F;
    logic       S;
    logic       door_open;
    logic [3:0] pend;

    modport slave (
        input  btn_g, btn_f_dn, btn_f_up, btn_s, car_btn, cur_floor,
        output G, F, S, door_open, pend
    );

    modport master (
        output btn_g, btn_f_dn, btn_f_up, btn_s, car_btn, cur_floor,
        input  G, F, S, door_open, pend
    );
endinterface

// File: rtl/lift_btn_sync.sv
// lift_btn_sync: WIDTH-bit two-flop synchroniser for asynchronous button
// levels.
//   clk   - destination clock
//   reset - asynchronous, active-high; both stages clear to 0
//   d     - raw button levels
//   q     - synchronised levels, two clk cycles behind d
module lift_btn_sync #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/lift_call_register.sv
// lift_call_register: latches hall/car calls into the lift controller's
// request inputs, runs a door dwell on arrival and clears served calls.
//   clk, reset - clock (rising edge) and asynchronous active-high reset
//   bus        - lift_call_register_if.slave: buttons and cur_floor in;
//                G, F, S, door_open and raw pend latches out
//   DWELL      - door-open time in clk cycles (>= 2)
// Optional build macro LIFT_CALL_SYNC_EN: buttons pass through a 2-flop
// synchroniser before the latch logic (two extra cycles of press latency).
module lift_call_register
    import lift_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    lift_call_register_if.slave  bus
);
    localparam int              CNT_W    = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_OPEN  = OPEN;
    localparam logic [1:0] ST_CLOSE = CLOSE;

    // {car_btn[2:0], btn_s, btn_f_up, btn_f_dn, btn_g}
    logic [6:0] btn_raw;
    logic [6:0] btn_vec;

    assign btn_raw = {bus.car_btn, bus.btn_s, bus.btn_f_up, bus.btn_f_dn, bus.btn_g};

`ifdef LIFT_CALL_SYNC_EN
    lift_btn_sync #(.WIDTH(7)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_vec)
    );
`else
    assign btn_vec = btn_raw;
`endif

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       pend_reg, pend_next;
    logic [1:0]       prev_floor_reg;
    logic             g_reg, s_reg, door_reg;
    logic [1:0]       f_reg;

    logic [3:0] set_vec;
    logic [3:0] here_mask;
    logic       here_set;
    logic       here_hit;
    logic       arrival;
    logic       gate_next;

    always_comb begin
        set_vec          = '0;
        set_vec[CALL_G]  = btn_vec[0] | btn_vec[4];
        set_vec[CALL_S]  = btn_vec[3] | btn_vec[6];
        // A car press for First becomes an up call only from Ground
        set_vec[CALL_FD] = btn_vec[1] | (btn_vec[5] & (bus.cur_floor != 2'd0));
        set_vec[CALL_FU] = btn_vec[2] | (btn_vec[5] & (bus.cur_floor == 2'd0));
    end

    assign here_mask = floor_mask(bus.cur_floor);
    assign here_set  = |(set_vec & here_mask);
    // A stationary car reopens for a call already pending here or being
    // pressed right now; the press never shows up on the request outputs.
    assign here_hit  = |((pend_reg | set_vec) & here_mask);
    assign arrival   = (bus.cur_floor != prev_floor_reg) && (bus.cur_floor != 2'd3);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg | set_vec;
        case (state_reg)
            ST_IDLE: begin
                if (arrival || here_hit) begin
                    state_next = ST_OPEN;
                    cnt_next   = CNT_LOAD;
                    pend_next  = (pend_reg | set_vec) & ~here_mask;
                end
            end
            ST_OPEN: begin
                // Clearing wins over a same-cycle press for this floor,
                // which instead restarts the dwell.
                pend_next = (pend_reg | set_vec) & ~here_mask;
                if (here_set) begin
                    cnt_next = CNT_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = ST_CLOSE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_CLOSE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Requests are only visible with the door shut and the car free to move
    assign gate_next = (state_next == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            pend_reg       <= '0;
            prev_floor_reg <= 2'd0;
            g_reg          <= 1'b0;
            f_reg          <= 2'b00;
            s_reg          <= 1'b0;
            door_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_reg       <= pend_next;
            prev_floor_reg <= bus.cur_floor;
            g_reg          <= gate_next & pend_next[CALL_G];
            f_reg          <= {2{gate_next}} & pend_next[CALL_FU:CALL_FD];
            s_reg          <= gate_next & pend_next[CALL_S];
            door_reg       <= (state_next == ST_OPEN);
        end
    end

    assign bus.G         = g_reg;
    assign bus.F         = f_reg;
    assign bus.S         = s_reg;
    assign bus.door_open = door_reg;
    assign bus.pend      = pend_reg;
endmodule

// File: tb/tb_lift_call_register.sv
// tb_lift_call_register: table vectors, hand-written corner sequences and a
// randomized run against a call-level reference model.
// Output vector compared everywhere: {door_open, S, F[1:0], G, pend[3:0]}.
// Button vector: {car_btn[2:0], btn_s, btn_f_up, btn_f_dn, btn_g}.
module tb_lift_call_register;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lift_call_register_if bus();

    lift_call_register #(.DWELL(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] btn;
        logic [1:0] cf;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[17];

    // ---------------- reference model (call level) ----------------
    bit m_pend[4];      // 0 G, 1 First-down, 2 First-up, 3 Second
    int m_left;         // door-open cycles still to run
    bit m_closing;      // the single shut-but-held cycle
    int m_prev;

    function automatic int call_floor(input int i);
        if (i == 0) return 0;
        if (i == 3) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_left    = 0;
        m_closing = 1'b0;
        m_prev    = 0;
    endtask

    task automatic model_step(input logic [6:0] b, input int cf);
        bit sets[4];
        bit here[4];
        bit hit, repress, arrive;
        sets[0] = b[0] | b[4];
        sets[3] = b[3] | b[6];
        sets[1] = b[1] | (b[5] && cf != 0);
        sets[2] = b[2] | (b[5] && cf == 0);
        arrive  = (cf != m_prev) && (cf != 3);
        hit     = 1'b0;
        repress = 1'b0;
        for (int i = 0; i < 4; i++) begin
            here[i] = (cf != 3) && (call_floor(i) == cf);
            if (here[i] && sets[i]) repress = 1'b1;
            if (here[i] && (sets[i] || m_pend[i])) hit = 1'b1;
        end
        if (m_left > 0) begin
            for (int i = 0; i < 4; i++) m_pend[i] = here[i] ? 1'b0 : (m_pend[i] | sets[i]);
            if (repress) m_left = DW;
            else begin
                m_left--;
                if (m_left == 0) m_closing = 1'b1;
            end
        end else if (m_closing) begin
            m_closing = 1'b0;
            for (int i = 0; i < 4; i++) m_pend[i] = m_pend[i] | sets[i];
        end else if (arrive || hit) begin
            m_left = DW;
            for (int i = 0; i < 4; i++) m_pend[i] = here[i] ? 1'b0 : (m_pend[i] | sets[i]);
        end else begin
            for (int i = 0; i < 4; i++) m_pend[i] = m_pend[i] | sets[i];
        end
        m_prev = cf;
    endtask

    function automatic logic [8:0] model_outs();
        logic gate;
        gate = (m_left == 0) && !m_closing;
        return {m_left > 0, gate & m_pend[3], gate & m_pend[2], gate & m_pend[1],
                gate & m_pend[0], m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [8:0] outs();
        return {bus.door_open, bus.S, bus.F, bus.G, bus.pend};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] b, input logic [1:0] cf);
        bus.btn_g     = b[0];
        bus.btn_f_dn  = b[1];
        bus.btn_f_up  = b[2];
        bus.btn_s     = b[3];
        bus.car_btn   = b[6:4];
        bus.cur_floor = cf;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(7'h00, 2'd0);
        step();
        reset = 1'b0;
        step();
        check("reset_state", 16'(outs()), 16'h0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] rb;
        logic [1:0] rcf;

        tbl[0]  = '{7'h00, 2'd0, 9'b0_0_00_0_0000};
        tbl[1]  = '{7'h08, 2'd0, 9'b0_1_00_0_1000};
        tbl[2]  = '{7'h00, 2'd0, 9'b0_1_00_0_1000};
        tbl[3]  = '{7'h20, 2'd0, 9'b0_1_10_0_1100};
        tbl[4]  = '{7'h00, 2'd1, 9'b1_0_00_0_1000};
        tbl[5]  = '{7'h01, 2'd1, 9'b1_0_00_0_1001};
        tbl[6]  = '{7'h20, 2'd1, 9'b1_0_00_0_1001};
        for (int i = 7; i <= 13; i++) tbl[i] = '{7'h00, 2'd1, 9'b1_0_00_0_1001};
        tbl[14] = '{7'h00, 2'd1, 9'b0_0_00_0_1001};
        tbl[15] = '{7'h00, 2'd1, 9'b0_1_00_1_1001};
        tbl[16] = '{7'h02, 2'd1, 9'b1_0_00_0_1001};

        // Reset held with every button pressed, released at Ground
        reset = 1'b1;
        drive(7'h7F, 2'd0);
        @(negedge clk);
        check("rst_hold_a", 16'(outs()), 16'h0);
        step();
        check("rst_hold_b", 16'(outs()), 16'h0);
        reset = 1'b0;
        step();
        check("rst_release", 16'(outs()), 16'(9'b1_0_00_0_1110));
        drive(7'h00, 2'd0);

        // Table vectors
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].btn, tbl[i].cf);
            step();
            check($sformatf("vec%0d", i), 16'(outs()), 16'(tbl[i].exp));
        end

        // Second-floor call served by arrival; exact dwell and CLOSE gating
        do_reset();
        drive(7'h08, 2'd0);
        step();
        check("s_pulse", 16'(outs()), 16'(9'b0_1_00_0_1000));
        drive(7'h00, 2'd0);
        step();
        check("s_hold", 16'(outs()), 16'(9'b0_1_00_0_1000));
        drive(7'h00, 2'd2);
        step();
        check("s_arrive", 16'(outs()), 16'(9'b1_0_00_0_0000));
        drive(7'h01, 2'd2);
        step();
        check("g_during_open", 16'(outs()), 16'(9'b1_0_00_0_0001));
        drive(7'h00, 2'd2);
        n = 2;
        while (bus.door_open && n < 30) begin
            step();
            if (bus.door_open) n++;
        end
        check("dwell_len", 16'(n), 16'(DW));
        check("close_gated", 16'(outs()), 16'(9'b0_0_00_0_0001));
        step();
        check("idle_g", 16'(outs()), 16'(9'b0_0_00_1_0001));

        // Car press for First from above is a down call; arrival clears it
        drive(7'h20, 2'd2);
        step();
        check("car_f_down", 16'(outs()), 16'(9'b0_0_01_1_0011));
        drive(7'h00, 2'd1);
        step();
        check("arr_first", 16'(outs()), 16'(9'b1_0_00_0_0001));
        n = 0;
        while (bus.door_open && n < 30) begin
            step();
            n++;
        end
        check("f_close", 16'(outs()), 16'(9'b0_0_00_0_0001));

        // Illegal floor holds latches; reset mid-dwell clears at once
        do_reset();
        drive(7'h08, 2'd0);
        step();
        drive(7'h00, 2'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("floor3_hold", 16'(outs()), 16'(9'b0_1_00_0_1000));
        end
        drive(7'h00, 2'd2);
        step();
        check("arr_from3", 16'(outs()), 16'(9'b1_0_00_0_0000));
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_mid_open", 16'(outs()), 16'h0);

        // Randomized run against the model
        do_reset();
        model_reset();
        rcf = 2'd0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 7; k++) rb[k] = ($urandom_range(7) == 0);
            if ($urandom_range(9) == 0) rcf = 2'($urandom_range(3));
            drive(rb, rcf);
            @(posedge clk);
            model_step(rb, int'(rcf));
            @(negedge clk);
            check($sformatf("rand%0d", c), 16'(outs()), 16'(model_outs()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
